multu_hilo_unit: RTL and testbench

//  Sequential unsigned shift-add multiplier with Hi/Lo result registers; direct consumer of the
//  6-bit function code from the ALU control stage. MULTU starts a WIDTH-cycle multiply.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_datapath.sv | 59 +++++
 rtl/multu_hilo_unit.sv | 124 ++++++++++++
 tb/tb_multu_hilo_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the Hi/Lo multiply unit: function codes from the
// ALU control stage, the FSM state encoding and default sizing.
package mul_pkg;

   localparam int MUL_WIDTH = 32;
   localparam int MUL_CNT_W = 6;

   // Function codes decoded by the multiply unit; all other codes are ignored.
   localparam logic [5:0] FN_MULTU     = 6'd25;
   localparam logic [5:0] FN_MFHI      = 6'd16;
   localparam logic [5:0] FN_MFLO      = 6'd18;
   localparam logic [5:0] FN_HILO_OPEN = 6'd63;

   // IDLE waits for MULTU, RUN iterates, DONE pulses, HOLD waits for MULTU to drop.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_HOLD = 2'd3
   } mul_state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiply datapath: operand registers, the WIDTH+1 bit adder on
// the accumulator's upper half, and the one-bit right shifter.
// With MULTU_EARLY_EXIT_EN defined an extra zero-detect output on the
// shifted multiplier lets the controller commit early.
module mul_datapath
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     dataA,
   input  logic [WIDTH-1:0]     dataB,
   output logic [2*WIDTH-1:0]   acc_next
`ifdef MULTU_EARLY_EXIT_EN
   ,
   output logic                 mplier_zero_next
`endif
);

   localparam int PW = 2 * WIDTH;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    acc;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] mplier_next;

   // One iteration: conditional add into the upper half (carry kept), then shift right.
   always_comb begin
      sum         = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
      acc_next    = PW'({sum, acc[WIDTH-1:0]} >> 1);
      mplier_next = mplier >> 1;
   end

`ifdef MULTU_EARLY_EXIT_EN
   // No set multiplier bits left means every remaining add would be zero.
   assign mplier_zero_next = (mplier_next == '0);
`endif

   // Operand and accumulator registers; load clears the accumulator for a new product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (load) begin
         mcand  <= dataA;
         mplier <= dataB;
         acc    <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mplier <= mplier_next;
      end
   end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned multiplier with Hi/Lo result registers. MULTU starts a
// multiply, MFHI/MFLO read the committed product onto dataOut.
// Optional feature macro: MULTU_EARLY_EXIT_EN (commit as soon as the
// remaining multiplier bits are all zero).
// Handshake: MULTU is a level, not a pulse; a start happens only from IDLE,
// so a code held across DONE parks in HOLD until a different code is seen.
// busy is high exactly while iterating, done is a single-cycle pulse.
module multu_hilo_unit
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int CNT_W = MUL_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] dataOut,
   output logic             busy,
   output logic             done
);

   localparam int               PW   = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   mul_state_t       state, state_nxt;
   logic             load, step, commit, last_iter;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] hi, lo;
   logic [PW-1:0]    acc_next;
   logic [PW-1:0]    commit_val;

`ifdef MULTU_EARLY_EXIT_EN
   logic mplier_zero_next;
`endif

   mul_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk              (clk),
      .reset            (reset),
      .load             (load),
      .step             (step),
      .dataA            (dataA),
      .dataB            (dataB),
      .acc_next         (acc_next)
`ifdef MULTU_EARLY_EXIT_EN
      ,
      .mplier_zero_next (mplier_zero_next)
`endif
   );

   // Decide when the current RUN edge is the last one, and what gets committed.
`ifdef MULTU_EARLY_EXIT_EN
   always_comb begin
      last_iter  = (cnt == LAST) || mplier_zero_next;
      commit_val = acc_next >> (LAST - cnt);
   end
`else
   always_comb begin
      last_iter  = (cnt == LAST);
      commit_val = acc_next;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and datapath controls.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      commit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (funct == FN_MULTU) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last_iter) begin
               commit    = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = (funct == FN_MULTU) ? ST_HOLD : ST_IDLE;
         ST_HOLD: if (funct != FN_MULTU) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Iteration counter, cleared on start and advanced on every RUN edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     cnt <= '0;
      else if (load) cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
   end

   // Hi/Lo only change on the commit edge, so reads during RUN see the old product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         {hi, lo} <= commit_val;
      end
   end

   // Result mux back onto the datapath.
   always_comb begin
      dataOut = '0;
      if (funct == FN_MFHI)      dataOut = hi;
      else if (funct == FN_MFLO) dataOut = lo;
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Bench for multu_hilo_unit: directed cases plus randomized multiplies
// checked against a 64-bit arithmetic reference and a latency model.
module tb_multu_hilo_unit;
   import mul_pkg::*;

   localparam int W = 32;
   localparam logic [5:0] FN_ADD = 6'd32;
   localparam logic [5:0] FN_SUB = 6'd34;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         reset;
   logic [5:0]   funct;
   logic [W-1:0] dataA, dataB, dataOut;
   logic         busy, done;

   always #5 clk = ~clk;

   multu_hilo_unit dut (
      .clk     (clk),
      .reset   (reset),
      .funct   (funct),
      .dataA   (dataA),
      .dataB   (dataB),
      .dataOut (dataOut),
      .busy    (busy),
      .done    (done)
   );

   // ---------------- scoreboard ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_prod = 64'd0;
   logic [5:0]  other_codes[7] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a, 6'h00, 6'd63};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: number of RUN cycles for a given multiplier.
   function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULTU_EARLY_EXIT_EN
      int n = 1;
      for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
      return n;
`else
      return W;
`endif
   endfunction

   // ---------------- driver tasks ----------------
   task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
      funct = FN_MFHI; #1 hi = dataOut;
      funct = FN_MFLO; #1 lo = dataOut;
      funct = FN_ADD;
   endtask

   // Start one multiply, optionally peek at Hi/Lo mid-run, then check result and latency.
   task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int mid);
      int          cycles = 0;
      int          lat;
      int          peek;
      logic        seen = 1'b0;
      logic [63:0] exp;
      logic [W-1:0] hi, lo;
      lat  = exp_lat(b);
      peek = (mid > lat) ? lat : mid;
      exp_q.push_back({32'd0, a} * {32'd0, b});
      @(negedge clk);
      funct = FN_MULTU; dataA = a; dataB = b;
      @(negedge clk);
      funct = FN_ADD; dataA = $urandom; dataB = $urandom;
      for (int t = 0; t < 200 && !seen; t++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) cycles++;
            if (peek > 0 && cycles == peek && busy) begin
               read_hilo(hi, lo);
               chk("mid_run_hi", {32'd0, hi}, {32'd0, last_prod[63:32]});
               chk("mid_run_lo", {32'd0, lo}, {32'd0, last_prod[31:0]});
            end
            @(negedge clk);
         end
      end
      exp = exp_q.pop_front();
      chk("done_seen", {63'd0, seen}, 64'd1);
      chk("run_cycles", 64'(cycles), 64'(lat));
      read_hilo(hi, lo);
      chk("prod", {hi, lo}, exp);
      last_prod = exp;
      @(negedge clk);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("idle_not_busy", {63'd0, busy}, 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [W-1:0] hi, lo;
      int pulses, bcount, rc;
      reset = 1'b1; funct = FN_ADD; dataA = '0; dataB = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      read_hilo(hi, lo);
      chk("rst_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);

      // directed products
      run_mult(32'd3, 32'd5, 0);
      run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_mult(32'd1, 32'd1, 0);
      run_mult(32'd2, 32'd2, 10);
      run_mult(32'd7, 32'd1, 0);
      run_mult(32'd1, 32'h80000000, 0);
      run_mult(32'hDEADBEEF, 32'd0, 3);

      // MULTU held for 100 cycles: one done pulse, no restart
      @(negedge clk);
      funct = FN_MULTU; dataA = 32'd6; dataB = 32'd7;
      pulses = 0; bcount = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         pulses += int'(done);
         bcount += int'(busy);
      end
      chk("hold_pulses", 64'(pulses), 64'd1);
      chk("hold_busy_cycles", 64'(bcount), 64'(exp_lat(32'd7)));
      funct = FN_SUB;
      @(negedge clk);
      chk("hold_release_busy", {63'd0, busy}, 64'd0);
      read_hilo(hi, lo);
      chk("hold_prod", {hi, lo}, 64'd42);
      last_prod = 64'd42;
      run_mult(32'd9, 32'd11, 5);

      // reset in the middle of a run discards everything
      @(negedge clk);
      funct = FN_MULTU; dataA = 32'h12345; dataB = 32'h80000001;
      @(negedge clk);
      funct = FN_ADD;
      rc = 0;
      for (int t = 0; t < 100 && rc < 17; t++) begin
         if (busy) rc++;
         if (rc < 17) @(negedge clk);
      end
      chk("rst_mid_reached", 64'(rc), 64'd17);
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      read_hilo(hi, lo);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      last_prod = 64'd0;
      run_mult(32'hCAFE, 32'hF00D0001, 20);

      // randomized products, interleaved with codes the unit must ignore
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] a, b;
         int sel;
         a = $urandom; b = $urandom;
         sel = $urandom_range(0, 5);
         if (sel == 0) b = b >> $urandom_range(1, 31);
         if (sel == 1) a = 32'hFFFFFFFF;
         if (sel == 2) b = 32'd0;
         @(negedge clk);
         funct = other_codes[$urandom_range(0, 6)];
         #1 chk("other_code_out", {32'd0, dataOut}, 64'd0);
         @(negedge clk);
         chk("other_code_idle", {63'd0, busy}, 64'd0);
         run_mult(a, b, $urandom_range(0, 40));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
